synth_control_unit: RTL

//  Front-panel controller for the wavetable synthesizer. Conditions the panel buttons, steps the

---
 rtl/synth_ctrl_pkg.sv | 16 +
 rtl/button_conditioner.sv | 46 ++++
 rtl/synth_control_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/synth_ctrl_pkg.sv
// Shared types and default timing constants for the synthesizer front-panel controller.
package synth_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RECORD = 2'd2,
        DONE   = 2'd3
    } rec_state_t;

    localparam int DEF_NUM_TABLES      = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REC_CLK_DIV     = 100000;
    localparam int DEF_REC_SAMPLES     = 4096;

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-FF synchroniser, stability debounce, rising-edge detect.
// Pulse appears DEBOUNCE_CYCLES stable cycles after the synchronised level changes; releases are silent.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive cycles the synchronised input disagrees with the accepted level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/synth_control_unit.sv
// Front-panel controller: button conditioning, wavetable select, mic clock divider and record FSM.
// Table steps and FSM react one CLK after a debounced press; REC_WE follows its sample tick by one CLK.
module synth_control_unit
    import synth_ctrl_pkg::*;
#(
    parameter int  NUM_TABLES      = DEF_NUM_TABLES,
    parameter int  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int  REC_CLK_DIV     = DEF_REC_CLK_DIV,
    parameter int  REC_SAMPLES     = DEF_REC_SAMPLES,
    localparam int TW              = $clog2(NUM_TABLES),
    localparam int AW              = $clog2(REC_SAMPLES)
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          BTN_UP,
    input  logic          BTN_DOWN,
    input  logic          BTN_REC,
    input  logic          MIC_IN,
    output logic [TW-1:0] TABLE_SEL,
    output logic          REC_CLK,
    output logic          REC_WE,
    output logic [AW-1:0] REC_ADDR,
    output logic          REC_DATA,
    output logic          REC_BUSY,
    output logic          REC_DONE,
    output logic          REC_ABORT,
    output logic [3:0]    LED
);

    localparam int HALF = REC_CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic w_up_press;
    logic w_dn_press;
    logic w_rec_press;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .i_clk(CLK), .i_rst_n(RESETN), .i_btn(BTN_UP), .o_press(w_up_press)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .i_clk(CLK), .i_rst_n(RESETN), .i_btn(BTN_DOWN), .o_press(w_dn_press)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_rec (
        .i_clk(CLK), .i_rst_n(RESETN), .i_btn(BTN_REC), .o_press(w_rec_press)
    );

    logic [DW-1:0] r_div_cnt;
    logic          r_rec_clk;
    logic          r_tick;

    // r_tick is high during the first CLK of each REC_CLK high phase
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_div_cnt <= '0;
            r_rec_clk <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (r_div_cnt == DW'(HALF - 1)) begin
                r_div_cnt <= '0;
                r_rec_clk <= ~r_rec_clk;
                r_tick    <= ~r_rec_clk;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end
        end
    end

    rec_state_t    r_state;
    rec_state_t    w_state_nxt;
    logic [TW-1:0] r_table;
    logic [TW-1:0] w_table_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic          r_we;
    logic          w_we_nxt;
    logic          r_data;
    logic          w_data_nxt;
    logic          r_abort;
    logic          w_abort_nxt;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= IDLE;
            r_table <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_data  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_table <= w_table_nxt;
            r_addr  <= w_addr_nxt;
            r_we    <= w_we_nxt;
            r_data  <= w_data_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_table_nxt = r_table;
        w_addr_nxt  = r_addr;
        w_we_nxt    = 1'b0;
        w_data_nxt  = r_data;
        w_abort_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A record press wins over a simultaneous step so the take lands on the shown table
                if (w_rec_press) begin
                    w_state_nxt = ARM;
                    w_addr_nxt  = '0;
                end else if (w_up_press && !w_dn_press) begin
                    w_table_nxt = (r_table == TW'(NUM_TABLES - 1)) ? '0 : r_table + TW'(1);
                end else if (w_dn_press && !w_up_press) begin
                    w_table_nxt = (r_table == '0) ? TW'(NUM_TABLES - 1) : r_table - TW'(1);
                end
            end
            ARM, RECORD: begin
                if (w_rec_press) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                    w_addr_nxt  = '0;
                end else begin
                    if (r_we) begin
                        if (r_addr == AW'(REC_SAMPLES - 1)) begin
                            w_addr_nxt  = '0;
                            w_state_nxt = DONE;
                        end else begin
                            w_addr_nxt = r_addr + AW'(1);
                        end
                    end
                    if (r_tick) begin
                        w_we_nxt    = 1'b1;
                        w_data_nxt  = MIC_IN;
                        w_state_nxt = RECORD;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    logic [2:0] w_led_tbl;

    generate
        if (TW >= 3) begin : g_led_wide
            assign w_led_tbl = r_table[2:0];
        end else begin : g_led_narrow
            assign w_led_tbl = {{(3 - TW){1'b0}}, r_table};
        end
    endgenerate

    assign TABLE_SEL = r_table;
    assign REC_CLK   = r_rec_clk;
    assign REC_WE    = r_we;
    assign REC_ADDR  = r_addr;
    assign REC_DATA  = r_data;
    assign REC_BUSY  = (r_state == ARM) || (r_state == RECORD);
    assign REC_DONE  = (r_state == DONE);
    assign REC_ABORT = r_abort;
    assign LED       = {REC_BUSY, w_led_tbl};

endmodule
